// File: rtl/i2c_pin_filter_if.sv
// Pad-side and filtered-side signals of the I2C pin filter.
// The slave modport is the filter's own view: raw pads in, clean lines and
// bus events out. The master modport is the view of the pad driver / the
// I2C master that consumes the filtered lines.
interface i2c_pin_filter_if;
  logic scl_pad_i;
  logic sda_pad_i;
  logic scl_o;
  logic sda_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic stop_o;
  logic bus_busy_o;

  modport slave (
    input  scl_pad_i,
    input  sda_pad_i,
    output scl_o,
    output sda_o,
    output scl_rise_o,
    output scl_fall_o,
    output start_o,
    output stop_o,
    output bus_busy_o
  );

  modport master (
    output scl_pad_i,
    output sda_pad_i,
    input  scl_o,
    input  sda_o,
    input  scl_rise_o,
    input  scl_fall_o,
    input  start_o,
    input  stop_o,
    input  bus_busy_o
  );
endinterface

// File: rtl/i2c_pin_filter.sv
// I2C pin filter: synchronises the raw SCL/SDA pads, removes glitches of
// up to filt_len_i cycles, and derives SCL edge pulses, START/STOP pulses
// and a bus-busy flag from the filtered lines. Every output comes straight
// from a flop, so there is no combinational input-to-output path.
// SYNC_STAGES must be at least 2 (the chain shift relies on it).
module i2c_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [FILT_W-1:0] filt_len_i,
  i2c_pin_filter_if.slave   bus
);

  // Line index 0 is SCL, line index 1 is SDA.
  localparam int LN_SCL = 0;
  localparam int LN_SDA = 1;

  localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
  localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};
  localparam logic [FILT_W-1:0] CNT_MAX  = {FILT_W{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [FILT_W-1:0]      cnt_q  [2];
  logic [FILT_W-1:0]      cnt_d  [2];
  logic [1:0]             filt_q;
  logic [1:0]             filt_d;
  logic [1:0]             sync_s;
  logic [1:0]             upd_s;
  logic [1:0]             pad_s;

  logic rise_q,  rise_d;
  logic fall_q,  fall_d;
  logic start_q, start_d;
  logic stop_q,  stop_d;

  bus_state_e state_q, state_d;

  assign pad_s = {bus.sda_pad_i, bus.scl_pad_i};

  // Synchroniser shift and per-line glitch filter next-state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pad_s[i]};
      sync_s[i] = sync_q[i][SYNC_STAGES-1];
      cnt_d[i]  = cnt_q[i];
      filt_d[i] = filt_q[i];
      upd_s[i]  = 1'b0;
      if (sync_s[i] == filt_q[i]) begin
        // Line agrees with the filtered value: any partial run is discarded.
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] >= filt_len_i) begin
        // Run is long enough (>= also resolves at once when N shrinks).
        filt_d[i] = sync_s[i];
        cnt_d[i]  = CNT_ZERO;
        upd_s[i]  = 1'b1;
      end else begin
        // Still inside a possible glitch: count, never wrap.
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge and START/STOP pulses, timed to coincide with the new line value.
  always_comb begin
    rise_d  = upd_s[LN_SCL] &  sync_s[LN_SCL];
    fall_d  = upd_s[LN_SCL] & ~sync_s[LN_SCL];
    // A START/STOP needs SCL stably high; a simultaneous SCL update is not one.
    start_d = upd_s[LN_SDA] & ~sync_s[LN_SDA] & filt_q[LN_SCL] & ~upd_s[LN_SCL];
    stop_d  = upd_s[LN_SDA] &  sync_s[LN_SDA] & filt_q[LN_SCL] & ~upd_s[LN_SCL];
  end

  // Bus FSM next-state, driven by the registered START/STOP pulses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (stop_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state: reset abandons everything at once and idles lines high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {SYNC_STAGES{1'b1}};
        cnt_q[i]  <= CNT_ZERO;
      end
      filt_q  <= 2'b11;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      state_q <= state_d;
    end
  end

  assign bus.scl_o      = filt_q[LN_SCL];
  assign bus.sda_o      = filt_q[LN_SDA];
  assign bus.scl_rise_o = rise_q;
  assign bus.scl_fall_o = fall_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.bus_busy_o = (state_q == ST_BUSY);

endmodule

// File: tb/tb_i2c_pin_filter.sv
// Bench for i2c_pin_filter: directed bus scenarios followed by random pad
// activity. A reference model pushes the expected outputs for every clock
// into a queue; a separate monitor pops and compares on the falling edge.
module tb_i2c_pin_filter;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_W      = 4;

  typedef struct packed {
    logic scl;
    logic sda;
    logic rise;
    logic fall;
    logic start;
    logic stop;
    logic busy;
  } exp_t;

  localparam exp_t RESET_EXP = '{scl: 1'b1, sda: 1'b1, rise: 1'b0, fall: 1'b0,
                                 start: 1'b0, stop: 1'b0, busy: 1'b0};

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [FILT_W-1:0] filt_len;
  logic              test_done = 1'b0;

  i2c_pin_filter_if bus_if ();

  i2c_pin_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .filt_len_i(filt_len),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: pad samples not yet visible at the sync point,
  // current filtered values, and how many consecutive sync samples have
  // disagreed with them.
  logic m_hist_scl[$];
  logic m_hist_sda[$];
  logic [1:0] m_filt;
  int   m_run [2];
  logic m_busy;
  logic m_prev_start;
  logic m_prev_stop;

  task automatic model_reset();
    m_hist_scl.delete();
    m_hist_sda.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_hist_scl.push_back(1'b1);
      m_hist_sda.push_back(1'b1);
    end
    m_filt       = 2'b11;
    m_run[0]     = 0;
    m_run[1]     = 0;
    m_busy       = 1'b0;
    m_prev_start = 1'b0;
    m_prev_stop  = 1'b0;
  endtask

  // One clock of the reference: a line's output follows the synchronised pad
  // once that pad has disagreed with it for N+1 consecutive cycles.
  task automatic model_step();
    logic [1:0] s;
    logic [1:0] f_old;
    logic [1:0] upd;
    exp_t e;
    int need;
    need  = int'(filt_len) + 1;
    s     = {m_hist_sda[0], m_hist_scl[0]};
    f_old = m_filt;
    for (int i = 0; i < 2; i++) begin
      if (s[i] != m_filt[i]) m_run[i] = m_run[i] + 1;
      else m_run[i] = 0;
      upd[i] = (m_run[i] >= need);
      if (upd[i]) begin
        m_filt[i] = s[i];
        m_run[i]  = 0;
      end
    end
    void'(m_hist_scl.pop_front());
    void'(m_hist_sda.pop_front());
    m_hist_scl.push_back(bus_if.scl_pad_i);
    m_hist_sda.push_back(bus_if.sda_pad_i);
    if (m_prev_start) m_busy = 1'b1;
    else if (m_prev_stop) m_busy = 1'b0;
    e.scl   = m_filt[0];
    e.sda   = m_filt[1];
    e.rise  = upd[0] && m_filt[0];
    e.fall  = upd[0] && !m_filt[0];
    e.start = upd[1] && !m_filt[1] && f_old[0] && !upd[0];
    e.stop  = upd[1] &&  m_filt[1] && f_old[0] && !upd[0];
    e.busy  = m_busy;
    m_prev_start = e.start;
    m_prev_stop  = e.stop;
    exp_q.push_back(e);
  endtask

  // Model runs on every rising edge, reading the same inputs the DUT sees.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_ni) begin
        model_reset();
        exp_q.push_back(RESET_EXP);
      end else begin
        model_step();
      end
    end
  end

  // Asynchronous reset: the current cycle's expectation becomes the reset state.
  initial begin
    forever begin
      @(negedge rst_ni);
      model_reset();
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = RESET_EXP;
    end
  end

  // Monitor: compare DUT outputs with the oldest expectation each falling edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{scl: bus_if.scl_o, sda: bus_if.sda_o, rise: bus_if.scl_rise_o,
                fall: bus_if.scl_fall_o, start: bus_if.start_o,
                stop: bus_if.stop_o, busy: bus_if.bus_busy_o};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got scl/sda/rise/fall/start/stop/busy=%b%b%b%b%b%b%b required %b%b%b%b%b%b%b",
                   $time, got.scl, got.sda, got.rise, got.fall, got.start, got.stop, got.busy,
                   e.scl, e.sda, e.rise, e.fall, e.start, e.stop, e.busy);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time.
  initial begin
    #3000000;
    if (!test_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout t=%0t stimulus did not complete", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic check_reset_state(input string tag);
    exp_t got;
    got = '{scl: bus_if.scl_o, sda: bus_if.sda_o, rise: bus_if.scl_rise_o,
            fall: bus_if.scl_fall_o, start: bus_if.start_o,
            stop: bus_if.stop_o, busy: bus_if.bus_busy_o};
    n_checks++;
    if (got !== RESET_EXP) begin
      n_fail++;
      $display("FAIL reset state (%s) t=%0t got scl/sda/rise/fall/start/stop/busy=%b%b%b%b%b%b%b required 1100000",
               tag, $time, got.scl, got.sda, got.rise, got.fall, got.start, got.stop, got.busy);
    end
  endtask

  task automatic drive(input logic scl, input logic sda, input int cycles);
    bus_if.scl_pad_i = scl;
    bus_if.sda_pad_i = sda;
    repeat (cycles) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then random pad activity.
  initial begin
    int r;
    logic scl_v;
    logic sda_v;
    rst_ni           = 1'b0;
    filt_len         = 4'd3;
    bus_if.scl_pad_i = 1'b1;
    bus_if.sda_pad_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("initial");
    #1 rst_ni = 1'b1;
    @(negedge clk);

    // N=3: a 3-cycle SDA glitch is rejected, a held low is a START.
    drive(1'b1, 1'b1, 8);
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    // Data phase, then repeated START, then STOP.
    drive(1'b0, 1'b0, 8);
    drive(1'b0, 1'b1, 8);
    drive(1'b1, 1'b1, 8);
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 8);
    drive(1'b1, 1'b0, 8);
    drive(1'b1, 1'b1, 10);
    // STOP-like edge while idle.
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 10);

    // N=0: both pads toggle on the same edge.
    filt_len = 4'd0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b1, 3);
    end
    drive(1'b1, 1'b1, 5);

    // N=15 with a run in progress, then N drops to 0.
    filt_len = 4'd15;
    drive(1'b1, 1'b0, 7);
    filt_len = 4'd0;
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 6);

    // Asynchronous reset while BUSY with SDA low.
    filt_len = 4'd2;
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 4);
    @(posedge clk);
    #1 rst_ni = 1'b0;
    #1 check_reset_state("async");
    repeat (3) @(negedge clk);
    #1 rst_ni = 1'b1;
    drive(1'b0, 1'b0, 6);
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 6);

    // Random pad activity with occasional filter-length changes.
    scl_v = 1'b1;
    sda_v = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) filt_len = FILT_W'($urandom_range(0, 5));
      r = $urandom_range(0, 3);
      case (r)
        0:       scl_v = ~scl_v;
        1, 2:    sda_v = ~sda_v;
        default: begin
          scl_v = ~scl_v;
          sda_v = ~sda_v;
        end
      endcase
      drive(scl_v, sda_v, $urandom_range(1, 8));
    end
    drive(1'b1, 1'b1, 30);

    test_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
